// File: rtl/lcd_cursor.sv
// HD44780 8-bit write-only controller: power-up init, then digit writes and cursor shifts from buttons.
// Optional macro LCD_CURSOR_HOME_EN: both cursor buttons pressed together issue Return Home (0x02).
module lcd_cursor #(
   parameter int DELAY_CYCLES = 20,
   parameter int STEP_CYCLES  = 20
) (
   input  logic       clk,
   input  logic       rst,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA,
   output logic [7:0] LED_out,
   input  logic [9:0] number_btn,
   input  logic [1:0] control_btn
);

   localparam int MAX_CYCLES = (DELAY_CYCLES > STEP_CYCLES) ? DELAY_CYCLES : STEP_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   // Encoding order matches the one-hot LED position (LED = 1 << state).
   typedef enum logic [2:0] {
      S_DELAY  = 3'd0,
      S_FSET   = 3'd1,
      S_DISP   = 3'd2,
      S_ENTRY  = 3'd3,
      S_CLEAR  = 3'd4,
      S_IDLE   = 3'd5,
      S_WRITE  = 3'd6,
      S_CURSOR = 3'd7
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            e_q, e_d;
   logic            rs_q, rs_d;
   logic [7:0]      data_q, data_d;
   logic [7:0]      led_q, led_d;
   logic [9:0]      num_prev_q;
   logic [1:0]      ctl_prev_q;

   logic [9:0]      num_edge_s;
   logic [1:0]      ctl_edge_s;
   logic [3:0]      digit_s;
   logic [7:0]      cursor_cmd_s;
   logic            delay_last_s;
   logic            step_last_s;
   logic            cmd_state_s;

   assign num_edge_s   = number_btn & ~num_prev_q;
   assign ctl_edge_s   = control_btn & ~ctl_prev_q;
   assign delay_last_s = (cnt_q == CW'(DELAY_CYCLES - 1));
   assign step_last_s  = (cnt_q == CW'(STEP_CYCLES - 1));

   // Lowest-index number edge wins.
   always_comb begin
      digit_s = 4'd0;
      for (int i = 9; i >= 0; i--) begin
         if (num_edge_s[i]) begin
            digit_s = 4'(i);
         end else begin
            digit_s = digit_s;
         end
      end
   end

   // Cursor command chosen from the control edges; left wins unless home is enabled.
   always_comb begin
      case (ctl_edge_s)
         2'b10:   cursor_cmd_s = 8'h14;
`ifdef LCD_CURSOR_HOME_EN
         2'b11:   cursor_cmd_s = 8'h02;
`endif
         default: cursor_cmd_s = 8'h10;
      endcase
   end

   // Next state and registered-output decode; outputs follow state_d so they switch with the state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CW'(1);
      rs_d        = rs_q;
      data_d      = data_q;
      led_d       = led_q;
      cmd_state_s = 1'b0;

      case (state_q)
         S_DELAY:  state_d = delay_last_s ? S_FSET  : S_DELAY;
         S_FSET:   state_d = step_last_s  ? S_DISP  : S_FSET;
         S_DISP:   state_d = step_last_s  ? S_ENTRY : S_DISP;
         S_ENTRY:  state_d = step_last_s  ? S_CLEAR : S_ENTRY;
         S_CLEAR:  state_d = step_last_s  ? S_IDLE  : S_CLEAR;
         S_IDLE: begin
            cnt_d = cnt_q;
            if (num_edge_s != 10'd0) begin
               state_d = S_WRITE;
            end else if (ctl_edge_s != 2'd0) begin
               state_d = S_CURSOR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE:  state_d = step_last_s ? S_IDLE : S_WRITE;
         S_CURSOR: state_d = step_last_s ? S_IDLE : S_CURSOR;
         default:  state_d = S_DELAY;
      endcase

      if (state_d != state_q) begin
         cnt_d = CW'(0);
         led_d = 8'h01 << state_d;
         case (state_d)
            S_FSET:   begin rs_d = 1'b0; data_d = 8'h38; end
            S_DISP:   begin rs_d = 1'b0; data_d = 8'h0F; end
            S_ENTRY:  begin rs_d = 1'b0; data_d = 8'h06; end
            S_CLEAR:  begin rs_d = 1'b0; data_d = 8'h01; end
            S_WRITE:  begin rs_d = 1'b1; data_d = 8'h30 + {4'd0, digit_s}; end
            S_CURSOR: begin rs_d = 1'b0; data_d = cursor_cmd_s; end
            default:  begin rs_d = 1'b0; data_d = 8'h00; end
         endcase
      end else begin
         led_d = led_q;
      end

      case (state_d)
         S_DELAY, S_IDLE: cmd_state_s = 1'b0;
         default:         cmd_state_s = 1'b1;
      endcase

      // Strobe sits strictly inside the step so RS/DATA have setup and hold around it.
      if (cmd_state_s && (cnt_d >= CW'(1)) && (cnt_d <= CW'(STEP_CYCLES / 2))) begin
         e_d = 1'b1;
      end else begin
         e_d = 1'b0;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_DELAY;
         cnt_q   <= CW'(0);
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         led_q   <= 8'h01;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         e_q     <= e_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         led_q   <= led_d;
      end
   end

   // Previous-sample registers for edge detection; they track the buttons in every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         num_prev_q <= 10'd0;
         ctl_prev_q <= 2'd0;
      end else begin
         num_prev_q <= number_btn;
         ctl_prev_q <= control_btn;
      end
   end

   assign LCD_E    = e_q;
   assign LCD_RS   = rs_q;
   assign LCD_RW   = 1'b0;
   assign LCD_DATA = data_q;
   assign LED_out  = led_q;

endmodule

// File: tb/tb_lcd_cursor.sv
// Bench for lcd_cursor: a queue of expected output frames ({E,RS,DATA,LED}) is compared every cycle.
module tb_lcd_cursor;

   localparam int DLY = 20;
   localparam int STP = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       LCD_E, LCD_RS, LCD_RW;
   logic [7:0] LCD_DATA, LED_out;
   logic [9:0] number_btn = 10'd0;
   logic [1:0] control_btn = 2'd0;

   int n_assert = 0;
   int n_fail   = 0;

   logic [17:0] init_q[$];
   logic [17:0] q[$];
   logic [9:0]  prev_num = 10'd0;
   logic [1:0]  prev_ctl = 2'd0;

   lcd_cursor #(.DELAY_CYCLES(DLY), .STEP_CYCLES(STP)) dut (
      .clk(clk), .rst(rst), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
      .LCD_DATA(LCD_DATA), .LED_out(LED_out), .number_btn(number_btn), .control_btn(control_btn)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] fr(input logic e, input logic rs, input logic [7:0] d, input logic [7:0] led);
      return {e, rs, d, led};
   endfunction

   // One LCD transaction: STP frames with E high for frames 1..STP/2, then back to IDLE.
   task automatic push_cmd(input logic rs, input logic [7:0] d, input logic [7:0] led);
      for (int i = 0; i < STP; i++) q.push_back(fr((i >= 1) && (i <= STP / 2), rs, d, led));
   endtask

   task automatic cycle();
      logic [17:0] exp;
      logic [9:0]  ne;
      logic [1:0]  ce;
      logic [7:0]  cmd;
      int          dig;
      if (rst) q = init_q;
      if (q.size() == 0) begin
         ne = number_btn & ~prev_num;
         ce = control_btn & ~prev_ctl;
         if (ne != 10'd0) begin
            dig = 0;
            while (!ne[dig]) dig++;
            push_cmd(1'b1, 8'h30 + 8'(dig), 8'h40);
            q.push_back(fr(1'b0, 1'b0, 8'h00, 8'h20));
         end else if (ce != 2'd0) begin
            if (ce == 2'b10) cmd = 8'h14;
`ifdef LCD_CURSOR_HOME_EN
            else if (ce == 2'b11) cmd = 8'h02;
`endif
            else cmd = 8'h10;
            push_cmd(1'b0, cmd, 8'h80);
            q.push_back(fr(1'b0, 1'b0, 8'h00, 8'h20));
         end
      end
      exp = (q.size() != 0) ? q.pop_front() : fr(1'b0, 1'b0, 8'h00, 8'h20);
      prev_num = rst ? 10'd0 : number_btn;
      prev_ctl = rst ? 2'd0 : control_btn;
      @(posedge clk);
      #1;
      n_assert++;
      assert ({LCD_E, LCD_RS, LCD_DATA, LED_out} === exp) else begin
         n_fail++;
         $error("FAIL frame t=%0t observed E=%b RS=%b DATA=%h LED=%h expected E=%b RS=%b DATA=%h LED=%h",
                $time, LCD_E, LCD_RS, LCD_DATA, LED_out, exp[17], exp[16], exp[15:8], exp[7:0]);
      end
      n_assert++;
      assert (LCD_RW === 1'b0) else begin
         n_fail++;
         $error("FAIL rw observed=%b expected=0", LCD_RW);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      for (int i = 0; i < DLY; i++) init_q.push_back(fr(1'b0, 1'b0, 8'h00, 8'h01));
      for (int i = 0; i < STP; i++) init_q.push_back(fr((i >= 1) && (i <= STP / 2), 1'b0, 8'h38, 8'h02));
      for (int i = 0; i < STP; i++) init_q.push_back(fr((i >= 1) && (i <= STP / 2), 1'b0, 8'h0F, 8'h04));
      for (int i = 0; i < STP; i++) init_q.push_back(fr((i >= 1) && (i <= STP / 2), 1'b0, 8'h06, 8'h08));
      for (int i = 0; i < STP; i++) init_q.push_back(fr((i >= 1) && (i <= STP / 2), 1'b0, 8'h01, 8'h10));
      init_q.push_back(fr(1'b0, 1'b0, 8'h00, 8'h20));

      // Reset and full init sequence.
      rst = 1'b1; run(2);
      rst = 1'b0; run(105);
      // Held digit 8: exactly one write.
      number_btn = 10'b01_0000_0000; run(100);
      number_btn = 10'd0; run(3);
      number_btn = 10'b00_0001_0000; run(30);
      number_btn = 10'd0; run(2);
      number_btn = 10'h201; run(30);
      number_btn = 10'd0; run(2);
      // Cursor left, right, number beats control, both arrows.
      control_btn = 2'b01; run(30);
      control_btn = 2'b00; run(2);
      control_btn = 2'b10; run(30);
      control_btn = 2'b00; run(2);
      number_btn = 10'b00_0000_1000; control_btn = 2'b01; run(30);
      number_btn = 10'd0; control_btn = 2'b00; run(2);
      control_btn = 2'b11; run(30);
      control_btn = 2'b00; run(2);
      // Press during init is discarded.
      rst = 1'b1; run(1);
      rst = 1'b0; run(49);
      control_btn = 2'b01; run(70);
      control_btn = 2'b00; run(3);
      // Press during write is discarded.
      number_btn = 10'b00_0000_0100; run(5);
      control_btn = 2'b10; run(25);
      number_btn = 10'd0; control_btn = 2'b00; run(3);
      // Reset mid-write at cnt=5.
      number_btn = 10'b00_1000_0000; run(6);
      rst = 1'b1; run(1);
      rst = 1'b0; number_btn = 10'd0; run(110);
      // Random buttons with rare resets.
      for (int k = 0; k < 3000; k++) begin
         case ($urandom_range(0, 15))
            0:       number_btn = 10'($urandom);
            1, 2:    number_btn = 10'd0;
            default: number_btn = number_btn;
         endcase
         case ($urandom_range(0, 15))
            0:       control_btn = 2'($urandom);
            1, 2:    control_btn = 2'd0;
            default: control_btn = control_btn;
         endcase
         rst = ($urandom_range(0, 599) == 0);
         cycle();
      end
      rst = 1'b0; run(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_cursor.md
Name: lcd_cursor

Overview:
- Controller for an HD44780-compatible character LCD in 8-bit, write-only mode.
- After reset it runs a fixed power-up command sequence, then idles and waits for user buttons.
- A digit button writes that ASCII digit at the cursor. Control buttons shift the cursor left or right.
- LED_out shows the current state one-hot, for board debug.
- Sits between board push-buttons and the LCD pin header.

Parameters:
- DELAY_CYCLES, 20, length in clk cycles of the power-up wait state (must be >= 4).
- STEP_CYCLES, 20, length in clk cycles of every command/data state (even, >= 4).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  register select (0 = instruction, 1 = data).
- LCD_RW  out  1  read/write select; constant 0 (write only).
- LCD_DATA  out  8  LCD data bus.
- LED_out  out  8  one-hot state indicator.
- number_btn  in  10  digit buttons; bit i means digit i; level inputs.
- control_btn  in  2  bit0 = cursor left, bit1 = cursor right; level inputs.

Behaviour:
- There is one clock domain. Reset is synchronous and active-high.
- Reset state is DELAY with counter 0. Reset outputs: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, LED_out=0x01.
- Button edge-detect registers reset to 0.
- States, LED_out value, RS/DATA driven for the whole state:
  - DELAY: 0x01, RS=0, DATA=0x00.
  - FUNCTION_SET: 0x02, RS=0, DATA=0x38.
  - DISP_ONOFF: 0x04, RS=0, DATA=0x0F (display on, cursor on, blink on).
  - ENTRY_MODE: 0x08, RS=0, DATA=0x06 (increment, no shift).
  - CLEAR_DISP: 0x10, RS=0, DATA=0x01.
  - IDLE: 0x20, RS=0, DATA=0x00.
  - WRITE: 0x40, RS=1, DATA=0x30+digit.
  - CURSOR: 0x80, RS=0, DATA=0x10 (left) or 0x14 (right).
- LED_out, LCD_RS and LCD_DATA are registered and change in the same cycle the state changes.
- A counter cnt resets to 0 on every state entry.
- DELAY lasts DELAY_CYCLES cycles. Every command/data state lasts STEP_CYCLES cycles.
- The state transition happens when cnt reaches (length-1).
- LCD_E=1 only while cnt is in 1..STEP_CYCLES/2 of a command/data state. It is 0 at cnt=0, in the second half, and in DELAY and IDLE. This keeps setup and hold around the strobe.
- Sequence: DELAY → FUNCTION_SET → DISP_ONOFF → ENTRY_MODE → CLEAR_DISP → IDLE.
- WRITE returns to IDLE; CURSOR returns to IDLE.
- Edge detection:
  - The previous-sample registers update every cycle.
  - A press is btn & ~prev.
  - Edges are acted on only in IDLE. Edges occurring in any other state are discarded, not queued.
  - A held button produces exactly one action.
- Arbitration in IDLE, evaluated in the same cycle:
  - Any number edge beats any control edge.
  - Among number edges, the lowest index wins.
  - Between control edges, left (bit0) wins, except when the optional feature below is enabled.
- The digit latched on WRITE entry is held for the whole state. LCD_DATA is 8 bits wide (0x30..0x39).
- The LCD's own address counter tracks the cursor, so the block holds no cursor position.
- Wrap-around at the line end is the LCD's behaviour; the block does not manage it.
- Reset asserted in any state, including mid-strobe, forces the reset values on the next edge and restarts the full init sequence.

Optional Feature:
- Macro: LCD_CURSOR_HOME_EN.
- Defined: if both control_btn bits show rising edges in the same IDLE cycle (and no number edge), enter CURSOR with DATA=0x02 (Return Home). Hold this state for STEP_CYCLES, as for any other CURSOR entry.
- Undefined: the same case is a left shift (0x10).

Test Plan:
- Reset, then release with defaults → LED_out steps 0x01 (20 cycles), 0x02/0x38, 0x04/0x0F, 0x08/0x06, 0x10/0x01, each 20 cycles with RS=0, then LED_out=0x20 at cycle 100. LCD_E goes high exactly 10 cycles per command; RW=0 throughout.
- After IDLE, number_btn=10'b01_0000_0000 (bit 8) held for 100 cycles → one WRITE: RS=1, DATA=0x38, one 10-cycle E pulse, then IDLE. No repeat while held.
- Switch to number_btn=10'b00_0001_0000 (bit 4) → WRITE with DATA=0x34. number_btn=0x201 → DATA=0x30 (lowest index wins).
- control_btn=2'b01 → CURSOR, RS=0, DATA=0x10. Then 2'b10 → 0x14. Simultaneous number edge and control edge → WRITE only.
- Press during WRITE or init (e.g. control_btn rises at cycle 50) → ignored; state returns to IDLE with no CURSOR state.
- Assert rst during WRITE at cnt=5 → next cycle LCD_E=0, DATA=0x00, LED_out=0x01; init sequence repeats.
